barret_sched_2789: RTL and testbench

BARRET_SCHED_2789 -- requirements
Module: barret_sched_2789

---
 rtl/barret_sched_2789_pkg.sv | 13 +
 rtl/barret_core_2789.sv | 27 ++
 rtl/barret_sched_2789.sv | 122 ++++++++++++
 tb/tb_barret_sched_2789.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/barret_sched_2789_pkg.sv
// rtl/barret_sched_2789_pkg.sv - shared constants for the mod-2789 Barrett reduction scheduler
package barret_sched_2789_pkg;

    localparam int Q_MOD = 2789;
    localparam int MU_C  = 6015;
    localparam int K_SH  = 12;
    localparam int Q_SQ  = 7778521;
    localparam int OP_W  = 23;
    localparam int RES_W = 12;
    // The first product (11-bit high part times 13-bit MU) needs one bit beyond the operand width
    localparam int PW    = OP_W + 1;

endpackage

// File: rtl/barret_core_2789.sv
// rtl/barret_core_2789.sv - combinational Barrett reduction of a 23-bit operand modulo Q
module barret_core_2789
    import barret_sched_2789_pkg::*;
#(
    parameter int Q  = Q_MOD,
    parameter int MU = MU_C,
    parameter int K  = K_SH
) (
    input  logic [OP_W-1:0]  a,
    output logic [RES_W-1:0] r
);

    logic [PW-1:0]   prod;
    logic [OP_W-1:0] t;
    logic [OP_W-1:0] tq;
    logic [OP_W-1:0] r0;
    logic [OP_W-1:0] r1;

    assign prod = PW'(a >> K) * PW'(MU);
    assign t    = OP_W'(prod >> K);
    // The quotient estimate never overshoots, so r0 cannot wrap below zero
    assign tq   = t * OP_W'(Q);
    assign r0   = a - tq;
    assign r1   = (r0 >= OP_W'(Q)) ? (r0 - OP_W'(Q)) : r0;
    assign r    = RES_W'(r1);

endmodule

// File: rtl/barret_sched_2789.sv
// rtl/barret_sched_2789.sv - two-port round-robin front end and two-stage Barrett residue pipeline
module barret_sched_2789
    import barret_sched_2789_pkg::*;
#(
    parameter int Q  = Q_MOD,
    parameter int MU = MU_C,
    parameter int K  = K_SH,
    parameter int TW = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OP_W-1:0]  req0_data,
    input  logic [TW-1:0]    req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OP_W-1:0]  req1_data,
    input  logic [TW-1:0]    req1_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [RES_W-1:0] resp_data,
    output logic             resp_src,
    output logic [TW-1:0]    resp_tag,
    output logic             resp_oor,
    output logic             idle,
    output logic [15:0]      done_cnt
);

    logic             ptr;
    logic             s1_valid;
    logic [OP_W-1:0]  s1_data;
    logic             s1_src;
    logic [TW-1:0]    s1_tag;
    logic             s2_valid;
    logic [RES_W-1:0] s2_data;
    logic             s2_src;
    logic [TW-1:0]    s2_tag;
    logic             s2_oor;

    logic             s2_load;
    logic             s1_load;
    logic             gnt0;
    logic             gnt1;
    logic             acc0;
    logic             acc1;
    logic             s1_oor;
    logic [RES_W-1:0] core_r;

    barret_core_2789 #(.Q(Q), .MU(MU), .K(K)) u_core (
        .a (s1_data),
        .r (core_r)
    );

    assign s2_load = !s2_valid || resp_ready;
    assign s1_load = !s1_valid || s2_load;

    // A lone requester always wins; the pointer only breaks ties
    assign gnt0 = req0_valid && (!req1_valid || !ptr);
    assign gnt1 = req1_valid && (!req0_valid || ptr);

    // rst_n gating keeps both ready lines low while reset is held
    assign req0_ready = rst_n && en && s1_load && gnt0;
    assign req1_ready = rst_n && en && s1_load && gnt1;
    assign acc0       = req0_valid && req0_ready;
    assign acc1       = req1_valid && req1_ready;

    assign s1_oor = (s1_data >= OP_W'(Q * Q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= 1'b0;
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_src   <= 1'b0;
            s1_tag   <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_src   <= 1'b0;
            s2_tag   <= '0;
            s2_oor   <= 1'b0;
            done_cnt <= '0;
        end else begin
            if (acc0 || acc1) begin
                ptr <= acc0;
            end
            if (s1_load) begin
                s1_valid <= acc0 || acc1;
                if (acc0) begin
                    s1_data <= req0_data;
                    s1_src  <= 1'b0;
                    s1_tag  <= req0_tag;
                end else if (acc1) begin
                    s1_data <= req1_data;
                    s1_src  <= 1'b1;
                    s1_tag  <= req1_tag;
                end
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s1_oor ? '0 : core_r;
                    s2_src  <= s1_src;
                    s2_tag  <= s1_tag;
                    s2_oor  <= s1_oor;
                end
            end
            if (s2_valid && resp_ready && (done_cnt != 16'hFFFF)) begin
                done_cnt <= done_cnt + 16'd1;
            end
        end
    end

    assign resp_valid = s2_valid;
    assign resp_data  = s2_data;
    assign resp_src   = s2_src;
    assign resp_tag   = s2_tag;
    assign resp_oor   = s2_oor;
    assign idle       = !s1_valid && !s2_valid;

endmodule

// File: tb/tb_barret_sched_2789.sv
// tb/tb_barret_sched_2789.sv - directed self-checking bench for barret_sched_2789
module tb_barret_sched_2789;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        req0_valid;
    logic        req0_ready;
    logic [22:0] req0_data;
    logic [3:0]  req0_tag;
    logic        req1_valid;
    logic        req1_ready;
    logic [22:0] req1_data;
    logic [3:0]  req1_tag;
    logic        resp_valid;
    logic        resp_ready;
    logic [11:0] resp_data;
    logic        resp_src;
    logic [3:0]  resp_tag;
    logic        resp_oor;
    logic        idle;
    logic [15:0] done_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    logic [22:0] bnd_op  [6];
    logic [11:0] bnd_res [6];
    logic        bnd_oor [6];

    always #5 clk = ~clk;

    barret_sched_2789 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_tag   (req0_tag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_tag   (req1_tag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_src   (resp_src),
        .resp_tag   (resp_tag),
        .resp_oor   (resp_oor),
        .idle       (idle),
        .done_cnt   (done_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bnd_op[0] = 23'd0;       bnd_res[0] = 12'd0;    bnd_oor[0] = 1'b0;
        bnd_op[1] = 23'd2789;    bnd_res[1] = 12'd0;    bnd_oor[1] = 1'b0;
        bnd_op[2] = 23'd5577;    bnd_res[2] = 12'd2788; bnd_oor[2] = 1'b0;
        bnd_op[3] = 23'd7775737; bnd_res[3] = 12'd5;    bnd_oor[3] = 1'b0;
        bnd_op[4] = 23'd7778521; bnd_res[4] = 12'd0;    bnd_oor[4] = 1'b1;
        bnd_op[5] = 23'd8388607; bnd_res[5] = 12'd0;    bnd_oor[5] = 1'b1;

        rst_n = 1'b0; en = 1'b1; resp_ready = 1'b1;
        req0_valid = 1'b1; req0_data = 23'd12345; req0_tag = 4'd3;
        req1_valid = 1'b1; req1_data = 23'd0;     req1_tag = 4'd0;
        @(negedge clk);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_resp_tag", resp_tag, 0);
        check("rst_idle", idle, 1);
        check("rst_done_cnt", done_cnt, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // single port 0 request
        req0_valid = 1'b1; req0_data = 23'd12345; req0_tag = 4'd3;
        #1;
        check("single_req0_ready", req0_ready, 1);
        check("single_req1_ready", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        check("single_mid_valid", resp_valid, 0);
        check("single_mid_idle", idle, 0);
        tick();
        check("single_valid", resp_valid, 1);
        check("single_data", resp_data, 1189);
        check("single_src", resp_src, 0);
        check("single_tag", resp_tag, 3);
        check("single_oor", resp_oor, 0);
        tick();
        check("single_drained", resp_valid, 0);
        check("single_idle", idle, 1);
        check("single_done_cnt", done_cnt, 1);

        // boundary and out-of-range operands streamed back to back
        for (int i = 0; i <= 6; i++) begin
            if (i < 6) begin
                req0_valid = 1'b1; req0_data = bnd_op[i]; req0_tag = 4'(i);
            end else begin
                req0_valid = 1'b0;
            end
            tick();
            if (i >= 1) begin
                check($sformatf("bnd_valid_%0d", i - 1), resp_valid, 1);
                check($sformatf("bnd_data_%0d", i - 1), resp_data, bnd_res[i - 1]);
                check($sformatf("bnd_oor_%0d", i - 1), resp_oor, bnd_oor[i - 1]);
                check($sformatf("bnd_tag_%0d", i - 1), resp_tag, i - 1);
            end
        end
        tick();
        check("bnd_idle", idle, 1);
        check("bnd_done_cnt", done_cnt, 7);

        // en=0 blocks grants
        en = 1'b0; req0_valid = 1'b1; req0_data = 23'd50;
        #1;
        check("en0_req0_ready", req0_ready, 0);
        tick();
        check("en0_idle", idle, 1);
        req0_valid = 1'b0; en = 1'b1;

        // contention from a fresh reset
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_data = 23'd1000; req0_tag = 4'd5;
        req1_valid = 1'b1; req1_data = 23'd2000; req1_tag = 4'd9;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("cont_ready0_%0d", i), req0_ready, (i % 2 == 0) ? 1 : 0);
            check($sformatf("cont_ready1_%0d", i), req1_ready, (i % 2 == 1) ? 1 : 0);
            tick();
            if (i >= 1) begin
                check($sformatf("cont_valid_%0d", i - 1), resp_valid, 1);
                check($sformatf("cont_src_%0d", i - 1), resp_src, (i - 1) % 2);
                check($sformatf("cont_data_%0d", i - 1), resp_data, ((i - 1) % 2 == 0) ? 1000 : 2000);
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        check("cont_valid_5", resp_valid, 1);
        check("cont_src_5", resp_src, 1);
        check("cont_tag_5", resp_tag, 9);
        tick();
        check("cont_idle", idle, 1);
        check("cont_done_cnt", done_cnt, 6);

        // backpressure with both ports valid
        resp_ready = 1'b0;
        req0_valid = 1'b1; req0_data = 23'd300; req0_tag = 4'd1;
        req1_valid = 1'b1; req1_data = 23'd400; req1_tag = 4'd2;
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("bp_valid_%0d", i), resp_valid, 1);
            check($sformatf("bp_data_%0d", i), resp_data, 300);
            check($sformatf("bp_src_%0d", i), resp_src, 0);
            check($sformatf("bp_tag_%0d", i), resp_tag, 1);
            check($sformatf("bp_ready0_%0d", i), req0_ready, 0);
            check($sformatf("bp_ready1_%0d", i), req1_ready, 0);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
        tick();
        check("bp_drain_valid", resp_valid, 1);
        check("bp_drain_data", resp_data, 400);
        check("bp_drain_src", resp_src, 1);
        tick();
        check("bp_idle", idle, 1);
        check("bp_done_cnt", done_cnt, 8);

        // reset while both stages hold entries
        resp_ready = 1'b0;
        req0_valid = 1'b1; req0_data = 23'd111; req0_tag = 4'd4;
        req1_valid = 1'b1; req1_data = 23'd222; req1_tag = 4'd6;
        tick();
        tick();
        check("mf_full_idle", idle, 0);
        rst_n = 1'b0;
        #1;
        check("mf_resp_valid", resp_valid, 0);
        check("mf_idle", idle, 1);
        check("mf_done_cnt", done_cnt, 0);
        check("mf_resp_data", resp_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
        tick();
        check("mf_no_stale", resp_valid, 0);
        req1_valid = 1'b1; req1_data = 23'd4000; req1_tag = 4'd7;
        tick();
        req1_valid = 1'b0;
        check("mf_new_mid", resp_valid, 0);
        tick();
        check("mf_new_valid", resp_valid, 1);
        check("mf_new_data", resp_data, 1211);
        check("mf_new_src", resp_src, 1);
        check("mf_new_tag", resp_tag, 7);
        tick();
        check("mf_new_done_cnt", done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
